light_zone_scheduler: RTL and testbench

//  Multi-zone lighting controller. Each zone runs an occupancy FSM with a hold-off timer,
//  so a light stays lit HOLD_CYCLES after motion stops. Lit-state changes go to one shared

---
 rtl/light_sched_pkg.sv | 14 +
 rtl/light_zone_fsm.sv | 96 +++++++++
 rtl/light_zone_scheduler.sv | 122 ++++++++++++
 tb/tb_light_zone_scheduler.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/light_sched_pkg.sv
// Shared types and constants for the multi-zone lighting scheduler.
// Optional feature macro: LIGHT_SCHED_OVERRIDE_EN (per-zone forced-on override input).
package light_sched_pkg;

    typedef enum logic [1:0] {
        Z_OFF  = 2'd0,
        Z_ON   = 2'd1,
        Z_HOLD = 2'd2
    } zone_state_t;

    localparam int COLOR_W = 3;
    localparam logic [COLOR_W-1:0] COLOR_OFF = 3'b000;

endpackage

// File: rtl/light_zone_fsm.sv
// One zone: occupancy FSM plus hold-off timer; zone_on is a registered lit flag.
// Optional feature macro: LIGHT_SCHED_OVERRIDE_EN adds the override_on input.
module light_zone_fsm
    import light_sched_pkg::*;
#(
    parameter int HOLD_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic motion,
    input  logic daylight,
`ifdef LIGHT_SCHED_OVERRIDE_EN
    input  logic override_on,
`endif
    output logic zone_on
);

    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

    zone_state_t      state_q;
    logic [CNT_W-1:0] timer_q;
    logic             on_q;
`ifdef LIGHT_SCHED_OVERRIDE_EN
    logic             ovr_q;
`endif

    // Zone state machine; daylight always wins, timer counts down only in Z_HOLD.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= Z_OFF;
            timer_q <= '0;
            on_q    <= 1'b0;
`ifdef LIGHT_SCHED_OVERRIDE_EN
            ovr_q   <= 1'b0;
`endif
        end else begin
`ifdef LIGHT_SCHED_OVERRIDE_EN
            ovr_q <= override_on;
            if (override_on) begin
                state_q <= Z_ON;
                on_q    <= 1'b1;
            end else if (ovr_q) begin
                // Release of override: fall into a fresh hold window unless it is daytime.
                if (daylight) begin
                    state_q <= Z_OFF;
                    on_q    <= 1'b0;
                end else begin
                    state_q <= Z_HOLD;
                    timer_q <= HOLD_LOAD;
                    on_q    <= 1'b1;
                end
            end else
`endif
            begin
                case (state_q)
                    Z_OFF: begin
                        if (motion && !daylight) begin
                            state_q <= Z_ON;
                            on_q    <= 1'b1;
                        end
                    end
                    Z_ON: begin
                        if (daylight) begin
                            state_q <= Z_OFF;
                            on_q    <= 1'b0;
                        end else if (!motion) begin
                            state_q <= Z_HOLD;
                            timer_q <= HOLD_LOAD;
                        end
                    end
                    Z_HOLD: begin
                        if (daylight) begin
                            state_q <= Z_OFF;
                            on_q    <= 1'b0;
                        end else if (motion) begin
                            state_q <= Z_ON;
                        end else if (timer_q == '0) begin
                            state_q <= Z_OFF;
                            on_q    <= 1'b0;
                        end else begin
                            timer_q <= timer_q - CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q <= Z_OFF;
                        on_q    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign zone_on = on_q;

endmodule

// File: rtl/light_zone_scheduler.sv
// Multi-zone lighting controller: per-zone FSMs, change tracking and a round-robin
// arbiter feeding one valid/ready light-driver command port.
// Optional feature macro: LIGHT_SCHED_OVERRIDE_EN (adds override_on input).
module light_zone_scheduler
    import light_sched_pkg::*;
#(
    parameter  int N_ZONES     = 4,
    parameter  int HOLD_CYCLES = 1000,
    localparam int IDX_W       = $clog2(N_ZONES)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_ZONES-1:0]         motion,
    input  logic                       daylight,
    input  logic [COLOR_W*N_ZONES-1:0] zone_color,
`ifdef LIGHT_SCHED_OVERRIDE_EN
    input  logic [N_ZONES-1:0]         override_on,
`endif
    output logic [N_ZONES-1:0]         zone_on,
    output logic                       cmd_valid,
    input  logic                       cmd_ready,
    output logic [IDX_W-1:0]           cmd_zone,
    output logic                       cmd_on,
    output logic [COLOR_W-1:0]         cmd_color
);

    logic [N_ZONES-1:0] zone_on_w;
    logic [N_ZONES-1:0] reported_q, reported_d;
    logic [N_ZONES-1:0] pending;
    logic               cmd_valid_q, cmd_valid_d;
    logic               cmd_on_q, cmd_on_d;
    logic [IDX_W-1:0]   cmd_zone_q, cmd_zone_d;
    logic [COLOR_W-1:0] cmd_color_q, cmd_color_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [IDX_W-1:0]   scan_idx, grant_idx;
    logic               grant_found;
    logic [COLOR_W-1:0] grant_color;

    for (genvar i = 0; i < N_ZONES; i++) begin : g_zone
        light_zone_fsm #(.HOLD_CYCLES(HOLD_CYCLES)) u_fsm (
            .clk        (clk),
            .reset      (reset),
            .motion     (motion[i]),
            .daylight   (daylight),
`ifdef LIGHT_SCHED_OVERRIDE_EN
            .override_on(override_on[i]),
`endif
            .zone_on    (zone_on_w[i])
        );
    end

    assign pending = zone_on_w ^ reported_q;

    // Round-robin search: scanning from the far end lets the entry nearest rr_q win last.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int k = N_ZONES - 1; k >= 0; k--) begin
            scan_idx = IDX_W'((int'(rr_q) + k) % N_ZONES);
            if (pending[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    // Colour mux for the granted zone.
    always_comb begin
        grant_color = COLOR_OFF;
        for (int i = 0; i < N_ZONES; i++) begin
            if (grant_idx == IDX_W'(i)) grant_color = zone_color[i*COLOR_W +: COLOR_W];
        end
    end

    // Command register: only loads while idle, so the cycle after a transfer is always a
    // gap cycle and the fields stay frozen while the driver stalls.
    always_comb begin
        reported_d  = reported_q;
        rr_d        = rr_q;
        cmd_valid_d = cmd_valid_q;
        cmd_zone_d  = cmd_zone_q;
        cmd_on_d    = cmd_on_q;
        cmd_color_d = cmd_color_q;
        if (cmd_valid_q && cmd_ready) begin
            reported_d[cmd_zone_q] = cmd_on_q;
            rr_d        = (cmd_zone_q == IDX_W'(N_ZONES - 1)) ? '0 : cmd_zone_q + IDX_W'(1);
            cmd_valid_d = 1'b0;
        end else if (!cmd_valid_q && grant_found) begin
            cmd_valid_d = 1'b1;
            cmd_zone_d  = grant_idx;
            cmd_on_d    = zone_on_w[grant_idx];
            cmd_color_d = zone_on_w[grant_idx] ? grant_color : COLOR_OFF;
        end
    end

    // Arbiter / command state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reported_q  <= '0;
            rr_q        <= '0;
            cmd_valid_q <= 1'b0;
            cmd_zone_q  <= '0;
            cmd_on_q    <= 1'b0;
            cmd_color_q <= COLOR_OFF;
        end else begin
            reported_q  <= reported_d;
            rr_q        <= rr_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_zone_q  <= cmd_zone_d;
            cmd_on_q    <= cmd_on_d;
            cmd_color_q <= cmd_color_d;
        end
    end

    assign zone_on   = zone_on_w;
    assign cmd_valid = cmd_valid_q;
    assign cmd_zone  = cmd_zone_q;
    assign cmd_on    = cmd_on_q;
    assign cmd_color = cmd_color_q;

endmodule

// File: tb/tb_light_zone_scheduler.sv
// Testbench for light_zone_scheduler (N_ZONES=4, HOLD_CYCLES=8): directed scenarios then
// random traffic, all cycles checked against a behavioural model.
module tb_light_zone_scheduler;

    localparam int NZ   = 4;
    localparam int HOLD = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  motion;
    logic        daylight;
    logic [11:0] zone_color;
    logic        cmd_ready;
`ifdef LIGHT_SCHED_OVERRIDE_EN
    logic [3:0]  override_on;
`endif
    logic [3:0]  zone_on;
    logic        cmd_valid;
    logic [1:0]  cmd_zone;
    logic        cmd_on;
    logic [2:0]  cmd_color;

    always #5 clk = ~clk;

    light_zone_scheduler #(.N_ZONES(NZ), .HOLD_CYCLES(HOLD)) dut (
        .clk        (clk),
        .reset      (reset),
        .motion     (motion),
        .daylight   (daylight),
        .zone_color (zone_color),
`ifdef LIGHT_SCHED_OVERRIDE_EN
        .override_on(override_on),
`endif
        .zone_on    (zone_on),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_zone   (cmd_zone),
        .cmd_on     (cmd_on),
        .cmd_color  (cmd_color)
    );

    int checks   = 0;
    int failures = 0;

    // Behavioural model: lit flag plus count of consecutive motion-free edges while lit.
    bit       m_lit[NZ];
    int       m_quiet[NZ];
    bit       m_rep[NZ];
    bit       m_ovr[NZ];
    bit       m_v;
    bit       m_on;
    int       m_z;
    int       m_rr;
    logic [2:0] m_col;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int z = 0; z < NZ; z++) begin
            m_lit[z] = 0; m_quiet[z] = 0; m_rep[z] = 0; m_ovr[z] = 0;
        end
        m_v = 0; m_on = 0; m_z = 0; m_rr = 0; m_col = 3'b000;
    endtask

    task automatic model_edge();
        bit old_lit[NZ];
        if (reset) begin
            model_reset();
            return;
        end
        for (int z = 0; z < NZ; z++) old_lit[z] = m_lit[z];
        if (m_v && cmd_ready) begin
            m_rep[m_z] = m_on;
            m_rr = (m_z + 1) % NZ;
            m_v = 0;
        end else if (!m_v) begin
            for (int k = 0; k < NZ; k++) begin
                int z = (m_rr + k) % NZ;
                if (old_lit[z] != m_rep[z]) begin
                    m_v = 1; m_z = z; m_on = old_lit[z];
                    m_col = m_on ? zone_color[3*z +: 3] : 3'b000;
                    break;
                end
            end
        end
        for (int z = 0; z < NZ; z++) begin
`ifdef LIGHT_SCHED_OVERRIDE_EN
            if (override_on[z]) begin
                m_lit[z] = 1; m_quiet[z] = 0; m_ovr[z] = 1;
                continue;
            end
            if (m_ovr[z]) begin
                m_ovr[z] = 0;
                m_lit[z] = !daylight;
                m_quiet[z] = daylight ? 0 : 1;
                continue;
            end
`endif
            if (daylight) begin
                m_lit[z] = 0; m_quiet[z] = 0;
            end else if (motion[z]) begin
                m_lit[z] = 1; m_quiet[z] = 0;
            end else if (m_lit[z]) begin
                m_quiet[z]++;
                if (m_quiet[z] > HOLD) begin
                    m_lit[z] = 0; m_quiet[z] = 0;
                end
            end
        end
    endtask

    task automatic check_all();
        logic [3:0] exp_on;
        for (int z = 0; z < NZ; z++) exp_on[z] = m_lit[z];
        chk("model_zone_on", zone_on, exp_on);
        chk("model_cmd_valid", cmd_valid, m_v);
        if (m_v) chk("model_cmd_fields", {cmd_zone, cmd_on, cmd_color}, {m_z[1:0], m_on, m_col});
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic wait_cmd(input string tag, input logic [6:0] exp);
        for (int i = 0; i < 10; i++) begin
            if (cmd_valid) break;
            step();
        end
        chk(tag, {cmd_valid, cmd_zone, cmd_on, cmd_color}, exp);
    endtask

    // Records the next three transfers (cmd_ready held high) and their spacing.
    task automatic collect3(input string tag, input int e0, input int e1, input int e2);
        int got[$];
        int exp[3];
        int tlast;
        exp[0] = e0; exp[1] = e1; exp[2] = e2;
        tlast = 0;
        for (int c = 0; c < 30 && got.size() < 3; c++) begin
            if (cmd_valid && cmd_ready) begin
                if (got.size() > 0) chk({tag, "_gap"}, c - tlast, 2);
                got.push_back(int'(cmd_zone));
                tlast = c;
            end
            step();
        end
        chk({tag, "_count"}, got.size(), 3);
        for (int i = 0; i < got.size(); i++) chk({tag, "_order"}, got[i], exp[i]);
    endtask

    initial begin
        int cnt;
        reset = 1'b1; motion = '0; daylight = 1'b0; zone_color = '0; cmd_ready = 1'b0;
`ifdef LIGHT_SCHED_OVERRIDE_EN
        override_on = '0;
`endif
        model_reset();
        step();
        step();
        chk("rst_zone_on", zone_on, 4'b0000);
        chk("rst_cmd", {cmd_valid, cmd_zone, cmd_on, cmd_color}, 7'd0);
        reset = 1'b0;

        // 1: zone 1 lights, command held stable while the driver stalls
        zone_color[5:3] = 3'b101;
        motion[1] = 1'b1;
        step();
        chk("t1_zone_on", zone_on[1], 1'b1);
        step();
        chk("t1_cmd", {cmd_valid, cmd_zone, cmd_on, cmd_color}, {1'b1, 2'd1, 1'b1, 3'b101});
        zone_color[5:3] = 3'b010;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t1_hold", {cmd_valid, cmd_zone, cmd_on, cmd_color}, {1'b1, 2'd1, 1'b1, 3'b101});
        end

        // 2: motion drops -> lit for 1+HOLD cycles, then off command
        motion[1] = 1'b0;
        cmd_ready = 1'b1;
        cnt = int'(zone_on[1]);
        for (int i = 0; i < 20; i++) begin
            step();
            if (zone_on[1]) cnt++;
            else break;
        end
        chk("t2_lit_cycles", cnt, 9);
        wait_cmd("t2_off_cmd", {1'b1, 2'd1, 1'b0, 3'b000});
        for (int i = 0; i < 4; i++) step();

        // 3: daylight kills a lit zone; motion ignored during daylight
        zone_color[8:6] = 3'b011;
        motion[2] = 1'b1;
        step();
        step();
        daylight = 1'b1;
        step();
        chk("t3_zone_off", zone_on[2], 1'b0);
        wait_cmd("t3_off_cmd", {1'b1, 2'd2, 1'b0, 3'b000});
        motion[3] = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("t3_daylight_motion", zone_on, 4'b0000);
        motion = '0;
        daylight = 1'b0;
        for (int i = 0; i < 4; i++) step();

        // 4: fresh pointer, three simultaneous zones, then a second round from pointer 0
        reset = 1'b1;
        step();
        reset = 1'b0;
        motion = 4'b1101;
        collect3("t4_first", 0, 2, 3);
        daylight = 1'b1;
        collect3("t4_second", 0, 2, 3);
        motion = '0;
        daylight = 1'b0;
        for (int i = 0; i < 4; i++) step();

        // 5: zone 3 turns off while its on-command is stalled -> reissued off
        cmd_ready = 1'b0;
        zone_color[11:9] = 3'b110;
        motion[3] = 1'b1;
        step();
        step();
        chk("t5_on_cmd", {cmd_valid, cmd_zone, cmd_on, cmd_color}, {1'b1, 2'd3, 1'b1, 3'b110});
        motion[3] = 1'b0;
        daylight = 1'b1;
        step();
        chk("t5_stale_held", {cmd_valid, cmd_zone, cmd_on, cmd_color}, {1'b1, 2'd3, 1'b1, 3'b110});
        cmd_ready = 1'b1;
        step();
        wait_cmd("t5_reissue", {1'b1, 2'd3, 1'b0, 3'b000});
        daylight = 1'b0;
        for (int i = 0; i < 3; i++) step();
        // zone 1 toggles on and back off while the port is busy -> no command for it
        cmd_ready = 1'b0;
        motion[0] = 1'b1;
        step();
        step();
        motion[1] = 1'b1;
        step();
        motion[1] = 1'b0;
        for (int i = 0; i < 12; i++) step();
        chk("t5_zone1_off", zone_on[1], 1'b0);
        cmd_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (cmd_valid && cmd_zone == 2'd1) cnt++;
            step();
        end
        chk("t5_no_zone1_cmd", cnt, 0);
        motion = '0;
        for (int i = 0; i < 14; i++) step();

        // 6: reset while a command is outstanding
        cmd_ready = 1'b0;
        motion[2] = 1'b1;
        step();
        step();
        chk("t6_pre_valid", cmd_valid, 1'b1);
        reset = 1'b1;
        motion = '0;
        #1;
        chk("t6_async_clear", {zone_on, cmd_valid, cmd_zone, cmd_on, cmd_color}, 11'd0);
        model_reset();
        step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t6_quiet", cmd_valid, 1'b0);
        end

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            for (int z = 0; z < NZ; z++) if ($urandom_range(7) == 0) motion[z] = ~motion[z];
            if ($urandom_range(49) == 0) daylight = ~daylight;
            zone_color = 12'($urandom);
            cmd_ready = ($urandom_range(2) != 0);
            step();
        end

`ifdef LIGHT_SCHED_OVERRIDE_EN
        daylight = 1'b1;
        override_on[0] = 1'b1;
        step();
        chk("ovr_forced_on", zone_on[0], 1'b1);
        override_on[0] = 1'b0;
        step();
        chk("ovr_release_day", zone_on[0], 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
